fixed_to_float_converter: RTL and testbench

- Converts a signed two's-complement fixed-point value into IEEE-754 single precision, rounding to nearest, ties to even.
- Sits downstream of the AI mixed-precision multiply path, turning wide fixed-point products back into float32 for the float register file and bus.
- Sequential normalizer with valid/ready handshakes on both sides; one conversion in flight at a time.

---
 rtl/fixed_to_float_converter.sv | 158 +++++++++++++++
 tb/tb_fixed_to_float_converter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_converter.sv
// fixed_to_float_converter: signed fixed-point (IN_WIDTH bits, FRAC_BITS
// fraction bits) to IEEE-754 single precision, round to nearest, ties to even.
// One conversion in flight; valid/ready handshakes on both sides.
// Build option FIXED_TO_FLOAT_FAST_NORM_EN: normalise in one cycle using a
// leading-zero count and barrel shift instead of the 1-bit-per-cycle shifter.
// Results are bit-identical; only latency changes.
module fixed_to_float_converter #(
  parameter int IN_WIDTH  = 64,
  parameter int FRAC_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                busy
);

  localparam int             LZ_W      = $clog2(IN_WIDTH) + 1;
  // Biased exponent of a value whose leading one sits in the top input bit.
  localparam logic [7:0]     EXP_BASE8 = 8'(IN_WIDTH - 1 - FRAC_BITS + 127);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [LZ_W-1:0]     lz_q, lz_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic [IN_WIDTH-1:0] in_abs;
  logic [23:0]         rnd_w;
  logic [7:0]          exp_w;

  // Round the 23 fraction bits below the leading one; bit 23 of the result
  // is the carry out of the fraction (mantissa becomes 1.0, exponent + 1).
  function automatic logic [23:0] round_rne(input logic [IN_WIDTH-2:0] f);
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    frac   = f[IN_WIDTH-2 -: 23];
    guard  = f[IN_WIDTH-25];
    sticky = |f[IN_WIDTH-26:0];
    return {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
  endfunction

`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
  logic [LZ_W-1:0] lz_fast;

  // Number of zero bits above the leading one (magnitude is known nonzero).
  function automatic logic [LZ_W-1:0] count_lz(input logic [IN_WIDTH-1:0] m);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n     = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  assign lz_fast = count_lz(mag_q);
`endif

  // Two's-complement magnitude; the most negative input maps to 2^(IN_WIDTH-1).
  assign in_abs = in_data[IN_WIDTH-1] ? -in_data : in_data;
  assign rnd_w  = round_rne(mag_q[IN_WIDTH-2:0]);
  assign exp_w  = EXP_BASE8 - 8'(lz_q) + {7'd0, rnd_w[23]};

  // Next-state and datapath decisions for the conversion FSM.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    lz_d       = lz_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d = in_data[IN_WIDTH-1];
          mag_d  = in_abs;
          lz_d   = '0;
          if (in_abs == '0) begin
            out_data_d = 32'h0000_0000;
            state_d    = OUT;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
        mag_d   = mag_q << lz_fast;
        lz_d    = lz_fast;
        state_d = ROUND;
`else
        if (mag_q[IN_WIDTH-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + LZ_W'(1);
        end
`endif
      end
      ROUND: begin
        // On carry the low 23 bits are already zero, i.e. mantissa 1.0.
        out_data_d = {sign_q, exp_w, rnd_w[22:0]};
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == OUT);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  // Working operand registers; always reloaded on acceptance, so no reset.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    mag_q  <= mag_d;
    lz_q   <= lz_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fixed_to_float_converter.sv
// Bench for fixed_to_float_converter (default IN_WIDTH=64, FRAC_BITS=32).
// A numeric model derives each float32 and latency from the value itself;
// directed vectors also carry hand-computed literal results.
module tb_fixed_to_float_converter;

  localparam int W    = 64;
  localparam int FRAC = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fixed_to_float_converter #(.IN_WIDTH(W), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Index of the most significant set bit of the magnitude (-1 for zero).
  function automatic int msb_of(input logic [W-1:0] v);
    logic [W-1:0] mag;
    int           m;
    mag = v[W-1] ? -v : v;
    m   = -1;
    for (int i = 0; i < W; i++) if (mag[i]) m = i;
    return m;
  endfunction

  // value = mag * 2^-FRAC; float = round_even(mag / 2^(msb-23)) * 2^(msb-FRAC-23)
  function automatic logic [31:0] model_float(input logic [W-1:0] v);
    logic         s;
    logic [W-1:0] mag, q, rem, half;
    int           msb, sh;
    logic [7:0]   e;
    s   = v[W-1];
    mag = s ? -v : v;
    if (mag == '0) return 32'h0;
    msb = msb_of(v);
    if (msb <= 23) begin
      q = mag << (23 - msb);
    end else begin
      sh   = msb - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q   = q >> 1;
        msb = msb + 1;
      end
    end
    e = 8'(msb - FRAC + 127);
    return {s, e, q[22:0]};
  endfunction

  // Clock edges after the acceptance edge until out_valid is visible.
  function automatic int model_lat(input logic [W-1:0] v);
    if (v == '0) return 0;
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
    return 2;
`else
    return (W - 1 - msb_of(v)) + 2;
`endif
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("busy_vs_in_ready", busy, ~in_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: got out_valid=1 data %h required no result", out_data);
        end else begin
          chk32("model_out_data", out_data, exp_q[0]);
          chk1("in_ready_during_out", in_ready, 1'b0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One conversion; optionally hold out_ready low for 10 cycles once valid.
  task automatic convert(input string name, input logic [W-1:0] v,
                         input logic [31:0] lit, input bit hold);
    int lat;
    int guard_cnt;
    @(posedge clk); #1;
    out_ready = hold ? 1'b0 : 1'b1;
    in_valid  = 1'b1;
    in_data   = v;
    guard_cnt = 0;
    do begin
      @(negedge clk);
      guard_cnt++;
    end while (!in_ready && guard_cnt < 200);
    if (!in_ready) begin
      chk1({name, "_accept_timeout"}, in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model_float(v));
    in_data = ~v ^ 64'h5A5A_0123_4567_89AB;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 300) break;
      lat++;
    end
    chk1({name, "_out_valid"}, out_valid, 1'b1);
    chk_int({name, "_latency"}, lat, model_lat(v));
    chk32({name, "_literal"}, out_data, lit);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk1({name, "_hold_valid"}, out_valid, 1'b1);
        chk32({name, "_hold_data"}, out_data, lit);
        chk1({name, "_hold_in_ready"}, in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1({name, "_post_valid"}, out_valid, 1'b0);
    chk1({name, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] v;
    logic [31:0]  lit;
  } vec_t;

  vec_t vecs[] = '{
    '{"pos_one",    64'h0000_0001_0000_0000, 32'h3F80_0000},
    '{"neg_one",    64'hFFFF_FFFF_0000_0000, 32'hBF80_0000},
    '{"most_neg",   64'h8000_0000_0000_0000, 32'hCF00_0000},
    '{"zero",       64'h0000_0000_0000_0000, 32'h0000_0000},
    '{"tie_even",   64'h0000_0001_0000_0100, 32'h3F80_0000},
    '{"tie_odd",    64'h0000_0001_0000_0300, 32'h3F80_0002},
    '{"mant_carry", 64'h0000_0001_FFFF_FFFF, 32'h4000_0000},
    '{"half",       64'h0000_0000_8000_0000, 32'h3F00_0000},
    '{"three_half", 64'h0000_0003_8000_0000, 32'h4060_0000},
    '{"max_pos",    64'h7FFF_FFFF_FFFF_FFFF, 32'h4F00_0000},
    '{"neg_lsb",    64'hFFFF_FFFF_FFFF_FFFF, 32'hAF80_0000}
  };

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk32("reset_out_data", out_data, 32'h0);
    chk1("reset_busy", busy, 1'b0);

    // Pin the model itself against the hand-computed results.
    foreach (vecs[i]) chk32({vecs[i].name, "_model"}, model_float(vecs[i].v), vecs[i].lit);

    foreach (vecs[i]) convert(vecs[i].name, vecs[i].v, vecs[i].lit, 1'b0);

    convert("backpressure", 64'hFFFF_FFFF_0000_0000, 32'hBF80_0000, 1'b1);

    // Reset right after acceptance aborts the conversion with no result.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 64'h0000_0001_0000_0000;
    @(negedge clk);
    chk1("abort_pre_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("abort_busy_before_rst", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk32("abort_out_data", out_data, 32'h0);
    repeat (80) @(negedge clk);

    convert("after_abort", 64'h0000_0001_0000_0300, 32'h3F80_0002, 1'b0);
    chk_int("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
